// File: rtl/conv_pkg.sv
// Shared sizes and FSM encoding for the KxK convolution window generator.
// Build option CONV_WIN_PAD_EN selects zero-padded windows centred on out_col.
package conv_pkg;

  localparam int PIX_W   = 8;
  localparam int ROW_PIX = 8;
  localparam int K       = 3;

  localparam int ROW_W = PIX_W * ROW_PIX;
  localparam int WIN_W = K * K * PIX_W;
  localparam int COL_W = 3;
  localparam int CNT_W = $clog2(K + 1);

`ifdef CONV_WIN_PAD_EN
  localparam int PAD      = (K - 1) / 2;
  localparam int LAST_COL = ROW_PIX - 1;
`else
  localparam int PAD      = 0;
  localparam int LAST_COL = ROW_PIX - K;
`endif

  typedef enum logic [1:0] {
    S_ACCEPT = 2'b00,
    S_SLIDE  = 2'b01,
    S_LAST   = 2'b10
  } state_e;

endpackage

// File: rtl/conv_window_gen_if.sv
// Row-in / window-out bus of conv_window_gen, plus the FSM state and overflow flag
// that the row buffer controller watches.
interface conv_window_gen_if;
  import conv_pkg::*;

  // Both channels: a transfer happens on a posedge where valid && ready (and the
  // block is enabled); the producer holds data stable while valid && !ready.
  logic               in_valid;
  logic [ROW_W-1:0]   in_row;
  logic               in_ready;
  logic [1:0]         state;
  logic               out_valid;
  logic               out_ready;
  logic [WIN_W-1:0]   out_win;
  logic [COL_W-1:0]   out_col;
  logic               ovf;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, state, out_valid, out_win, out_col, ovf
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, state, out_valid, out_win, out_col, ovf
  );

endinterface

// File: rtl/conv_win_mux.sv
// Picks K adjacent pixels from one stored row for a window column; under
// CONV_WIN_PAD_EN the column is the centre pixel and out-of-row pixels read 0.
module conv_win_mux
  import conv_pkg::*;
(
  input  logic [ROW_W-1:0]   row_i,
  input  logic [COL_W-1:0]   col_i,
  output logic [K*PIX_W-1:0] pix_o
);

  always_comb begin
    int idx;
    pix_o = '0;
    idx   = 0;
    for (int c = 0; c < K; c++) begin
`ifdef CONV_WIN_PAD_EN
      idx = int'(col_i) + c - PAD;
`else
      idx = int'(col_i) + c;
`endif
      if (idx >= 0 && idx < ROW_PIX) begin
        pix_o[c*PIX_W +: PIX_W] = row_i[idx*PIX_W +: PIX_W];
      end
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Keeps the last K rows from the row buffer controller and streams registered KxK
// windows, one column per handshake. Padding mode: CONV_WIN_PAD_EN.
module conv_window_gen
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  conv_window_gen_if.slave bus
);

  logic [ROW_W-1:0] row_q [K];
  logic [ROW_W-1:0] row_d [K];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             valid_q, valid_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             ovf_q, ovf_d;

  logic             in_ready;
  logic [COL_W-1:0] col_nxt;
  logic [COL_W-1:0] sel_col;
  logic [WIN_W-1:0] win_mux;

  assign in_ready = (state_q == S_ACCEPT);
  assign col_nxt  = col_q + 1'b1;
  // Window register loads the column being entered: col 0 on the first load, col+1 on a handshake.
  assign sel_col  = valid_q ? col_nxt : col_q;

  for (genvar r = 0; r < K; r++) begin : g_mux
    conv_win_mux u_mux (
      .row_i (row_q[r]),
      .col_i (sel_col),
      .pix_o (win_mux[r*K*PIX_W +: K*PIX_W])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    valid_d = valid_q;
    win_d   = win_q;
    ovf_d   = ovf_q;
    row_d   = row_q;

    if (bus.in_valid && !in_ready) ovf_d = 1'b1;

    case (state_q)
      S_ACCEPT: begin
        valid_d = 1'b0;
        if (bus.in_valid) begin
          for (int r = 0; r < K - 1; r++) row_d[r] = row_q[r+1];
          row_d[K-1] = bus.in_row;
          if (cnt_q < CNT_W'(K)) cnt_d = cnt_q + 1'b1;
          if (cnt_q >= CNT_W'(K - 1)) begin
            state_d = (LAST_COL == 0) ? S_LAST : S_SLIDE;
            col_d   = '0;
          end
        end
      end
      S_SLIDE, S_LAST: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          win_d   = win_mux;
        end else if (bus.out_ready) begin
          if (state_q == S_LAST) begin
            state_d = S_ACCEPT;
            valid_d = 1'b0;
          end else begin
            col_d = col_nxt;
            win_d = win_mux;
            if (col_nxt == COL_W'(LAST_COL)) state_d = S_LAST;
          end
        end
      end
      default: begin
        state_d = S_ACCEPT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < K; r++) row_q[r] <= '0;
      cnt_q   <= '0;
      state_q <= S_ACCEPT;
      col_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      // Frame restart keeps the sticky overflow so the controller can still see it.
      cnt_q   <= '0;
      state_q <= S_ACCEPT;
      valid_q <= 1'b0;
    end else if (en) begin
      for (int r = 0; r < K; r++) row_q[r] <= row_d[r];
      cnt_q   <= cnt_d;
      state_q <= state_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      win_q   <= win_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.state     = state_q;
  assign bus.out_valid = valid_q;
  assign bus.out_win   = win_q;
  assign bus.out_col   = col_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: queue-based window model, directed scenarios, random traffic.
// Honours CONV_WIN_PAD_EN the same way the design does.
module tb_conv_window_gen;
  import conv_pkg::*;

`ifdef CONV_WIN_PAD_EN
  localparam int TB_PAD  = (K - 1) / 2;
  localparam int TB_NWIN = ROW_PIX;
`else
  localparam int TB_PAD  = 0;
  localparam int TB_NWIN = ROW_PIX - K + 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic en    = 1'b0;
  logic clear = 1'b0;

  always #5 clk = ~clk;

  conv_window_gen_if bus ();

  conv_window_gen dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clear (clear),
    .bus   (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [COL_W+WIN_W-1:0] exp_q[$];
  logic [ROW_W-1:0]       hist[$];
  bit                     fresh = 1'b0;
  bit                     ovf_m = 1'b0;

  task automatic chk(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [ROW_W-1:0] mk_row(input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int i = 0; i < ROW_PIX; i++) v[i*PIX_W +: PIX_W] = PIX_W'(8 * r + i);
    return v;
  endfunction

  // Window over fill-pattern rows base..base+K-1 (pixel i of row r is 8r+i).
  function automatic logic [WIN_W-1:0] fill_win(input int base, input int col);
    logic [WIN_W-1:0] w;
    int p;
    w = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        p = col + c - TB_PAD;
        if (p >= 0 && p < ROW_PIX) w[(r*K+c)*PIX_W +: PIX_W] = PIX_W'(8 * (base + r) + p);
      end
    end
    return w;
  endfunction

  // Window built from the last K accepted rows held in hist.
  function automatic logic [WIN_W-1:0] model_win(input int col);
    logic [WIN_W-1:0] w;
    logic [ROW_W-1:0] rw;
    int p;
    w = '0;
    for (int r = 0; r < K; r++) begin
      rw = hist[r];
      for (int c = 0; c < K; c++) begin
        p = col + c - TB_PAD;
        if (p >= 0 && p < ROW_PIX) w[(r*K+c)*PIX_W +: PIX_W] = rw[p*PIX_W +: PIX_W];
      end
    end
    return w;
  endfunction

  // Model: pending windows live in exp_q; the block only takes rows when none are pending,
  // and the first window of a set appears one enabled cycle after the filling row.
  always @(posedge clk) begin
    bit ready_m;
    bit valid_m;
    if (!rst) begin
      exp_q.delete();
      hist.delete();
      fresh = 1'b0;
      ovf_m = 1'b0;
    end else if (clear) begin
      exp_q.delete();
      hist.delete();
      fresh = 1'b0;
    end else if (en) begin
      ready_m = (exp_q.size() == 0);
      valid_m = (exp_q.size() != 0) && !fresh;
      fresh   = 1'b0;
      if (valid_m && bus.out_ready) void'(exp_q.pop_front());
      if (bus.in_valid && !ready_m) ovf_m = 1'b1;
      if (bus.in_valid && ready_m) begin
        hist.push_back(bus.in_row);
        if (hist.size() > K) void'(hist.pop_front());
        if (hist.size() == K) begin
          for (int c = 0; c < TB_NWIN; c++) exp_q.push_back({COL_W'(c), model_win(c)});
          fresh = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit                     valid_m;
    logic [1:0]             st_m;
    logic [COL_W+WIN_W-1:0] e;
    if (chk_en) begin
      valid_m = (exp_q.size() != 0) && !fresh;
      st_m    = (exp_q.size() == 0) ? 2'b00 : ((exp_q.size() == 1) ? 2'b10 : 2'b01);
      chk("in_ready", bus.in_ready, exp_q.size() == 0);
      chk("out_valid", bus.out_valid, valid_m);
      chk("state", bus.state, st_m);
      chk("ovf", bus.ovf, ovf_m);
      if (valid_m) begin
        e = exp_q[0];
        chk("out_win", bus.out_win, e[WIN_W-1:0]);
        chk("out_col", bus.out_col, e[COL_W+WIN_W-1:WIN_W]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [ROW_W-1:0] r);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_row   = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_col(input int col, input string name);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_col == COL_W'(col)) && n < 200) begin tick(); n++; end
    if (n >= 200) chk(name, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) chk(name, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int               cnt;
    int               lit_first[9];
    int               lit_last[9];
    logic [WIN_W-1:0] w;
    logic [WIN_W-1:0] last_w;

`ifdef CONV_WIN_PAD_EN
    lit_first = '{0, 0, 1, 0, 8, 9, 0, 16, 17};
    lit_last  = '{6, 7, 0, 14, 15, 0, 22, 23, 0};
`else
    lit_first = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    lit_last  = '{5, 6, 7, 13, 14, 15, 21, 22, 23};
`endif
    last_w        = '0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b0; en = 1'b1; clear = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_state", bus.state, 2'b00);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_out_col", bus.out_col, 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Fill: three rows, first window one cycle after the third row
    bus.out_ready = 1'b1;
    send(mk_row(0)); send(mk_row(1)); send(mk_row(2));
    chk("fill_not_yet_valid", bus.out_valid, 0);
    tick();
    chk("fill_first_valid", bus.out_valid, 1);
    chk("fill_first_col", bus.out_col, 0);
    w = bus.out_win;
    for (int i = 0; i < 9; i++) chk("fill_first_pix", w[i*PIX_W +: PIX_W], PIX_W'(lit_first[i]));
    chk("fill_first_formula", w, fill_win(0, 0));
    cnt = 0;
    for (int n = 0; n < 50 && !bus.in_ready; n++) begin
      if (bus.out_valid) begin
        cnt++;
        if (bus.out_col == COL_W'(TB_NWIN - 1)) last_w = bus.out_win;
      end
      tick();
    end
    chk("fill_win_count", cnt, TB_NWIN);
    for (int i = 0; i < 9; i++) chk("fill_last_pix", last_w[i*PIX_W +: PIX_W], PIX_W'(lit_last[i]));
    chk("fill_idle_state", bus.state, 2'b00);

    // Backpressure at out_col 2
    send(mk_row(3));
    wait_col(2, "bp_reach_col2");
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_col", bus.out_col, 2);
      chk("bp_win", bus.out_win, fill_win(1, 2));
      chk("bp_state", bus.state, 2'b01);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;

    // Overflow: row offered while sliding is dropped, ovf sticks through clear
    tick();
    bus.in_valid = 1'b1;
    bus.in_row   = mk_row(9);
    tick();
    bus.in_valid = 1'b0;
    chk("ovf_set", bus.ovf, 1);
    wait_idle("ovf_idle");
    clear = 1'b1; tick(); clear = 1'b0;
    chk("ovf_after_clear", bus.ovf, 1);

    // Clear mid-window, then three fresh rows are needed
    send(mk_row(10)); send(mk_row(11)); send(mk_row(12));
    wait_col(3, "clr_reach_col3");
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_in_ready", bus.in_ready, 1);
    send(mk_row(13)); send(mk_row(14));
    tick(); tick();
    chk("clr_partial_no_win", bus.out_valid, 0);
    send(mk_row(15));
    tick();
    chk("clr_refill_valid", bus.out_valid, 1);
    chk("clr_refill_win", bus.out_win, fill_win(13, 0));

    // en low mid-slide freezes everything
    wait_col(1, "en_reach_col1");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("en_col", bus.out_col, 1);
      chk("en_valid", bus.out_valid, 1);
      chk("en_win", bus.out_win, fill_win(13, 1));
    end
    en = 1'b1;
    tick();
    chk("en_resume_col", bus.out_col, 2);
    wait_idle("en_idle");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.in_valid  = ($urandom_range(0, 2) == 0);
      bus.in_row    = {$urandom, $urandom};
      bus.out_ready = ($urandom_range(0, 3) != 0);
      en            = ($urandom_range(0, 9) != 0);
      clear         = ($urandom_range(0, 99) == 0);
      rst           = ($urandom_range(0, 599) != 0);
      tick();
    end
    rst = 1'b1; clear = 1'b0; en = 1'b1; bus.in_valid = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
